// File: rtl/viterbi_pkg.sv
// Shared defaults and types for the Viterbi ACS sequencer.
package viterbi_pkg;

    localparam int unsigned NSTATES_DFLT     = 8;
    localparam int unsigned PM_W_DFLT        = 4;
    localparam int unsigned TB_DEPTH_DFLT    = 16;
    localparam int unsigned NORM_THRESH_DFLT = 12;
    localparam int unsigned SM_AW_DFLT       = $clog2(TB_DEPTH_DFLT);

    typedef enum logic [2:0] {
        StIdle,
        StAcs,
        StStore,
        StNorm,
        StTb
    } acs_sched_state_t;

endpackage

// File: rtl/pm_min_tree.sv
// Combinational log2(NSTATES)-level minimum over packed path metrics.
// NSTATES must be a power of two; ties resolve to the lower state index.
module pm_min_tree #(
    parameter int unsigned NSTATES = 8,
    parameter int unsigned PM_W    = 4
) (
    input  logic [NSTATES*PM_W-1:0] pm_in,
    output logic [PM_W-1:0]         min_pm
);

    localparam int unsigned Levels = $clog2(NSTATES);

    for (genvar l = 0; l <= Levels; l++) begin : g_lvl
        localparam int unsigned Cnt = NSTATES >> l;
        logic [PM_W-1:0] v [Cnt];
        for (genvar k = 0; k < Cnt; k++) begin : g_node
            if (l == 0) begin : g_leaf
                assign v[k] = pm_in[k*PM_W +: PM_W];
            end else begin : g_cmp
                // Strict less-than keeps the even (lower-index) child on ties.
                assign v[k] = (g_lvl[l-1].v[2*k+1] < g_lvl[l-1].v[2*k]) ?
                              g_lvl[l-1].v[2*k+1] : g_lvl[l-1].v[2*k];
            end
        end
    end

    assign min_pm = g_lvl[Levels].v[0];

endmodule

// File: rtl/acs_sched_ctrl.sv
// Step sequencer for the 8-state ACS unit: accept, update, store, normalise, traceback.
// Optional build macro ACS_NORM_STATS_EN adds a saturating norm_count output.
module acs_sched_ctrl
    import viterbi_pkg::*;
#(
    parameter int unsigned NSTATES     = NSTATES_DFLT,
    parameter int unsigned PM_W        = PM_W_DFLT,
    parameter int unsigned TB_DEPTH    = TB_DEPTH_DFLT,
    parameter int unsigned NORM_THRESH = NORM_THRESH_DFLT
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        sym_valid,
    output logic                        sym_ready,
    input  logic                        frame_last,
    output logic                        aen,
    input  logic [NSTATES*PM_W-1:0]     pm_in,
    input  logic [NSTATES-1:0]          label_in,
    output logic                        pm_norm_en,
    output logic [PM_W-1:0]             pm_norm_val,
    output logic                        sm_we,
    output logic [$clog2(TB_DEPTH)-1:0] sm_waddr,
    output logic [NSTATES-1:0]          sm_wdata,
    output logic                        tb_start,
    output logic [$clog2(TB_DEPTH)-1:0] tb_addr,
    input  logic                        tb_done,
`ifdef ACS_NORM_STATS_EN
    output logic [7:0]                  norm_count,
`endif
    output logic                        busy
);

    localparam int unsigned SM_AW = $clog2(TB_DEPTH);

    acs_sched_state_t state_q;
    logic             last_q;
    logic             tb_pend_q;
    logic [PM_W-1:0]  min_pm;
    logic             store_tb;

    pm_min_tree #(
        .NSTATES (NSTATES),
        .PM_W    (PM_W)
    ) u_min (
        .pm_in  (pm_in),
        .min_pm (min_pm)
    );

    // Labels are already registered by the ACS; gating keeps the bus quiet outside STORE.
    assign sm_wdata = sm_we ? label_in : '0;
    assign store_tb = last_q || (sm_waddr == SM_AW'(TB_DEPTH - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            last_q      <= 1'b0;
            tb_pend_q   <= 1'b0;
            sym_ready   <= 1'b0;
            aen         <= 1'b0;
            pm_norm_en  <= 1'b0;
            pm_norm_val <= '0;
            sm_we       <= 1'b0;
            sm_waddr    <= '0;
            tb_start    <= 1'b0;
            tb_addr     <= '0;
            busy        <= 1'b0;
`ifdef ACS_NORM_STATS_EN
            norm_count  <= 8'd0;
`endif
        end else begin
            sym_ready   <= 1'b0;
            aen         <= 1'b0;
            pm_norm_en  <= 1'b0;
            pm_norm_val <= '0;
            sm_we       <= 1'b0;
            tb_start    <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (sym_valid && sym_ready) begin
                        state_q <= StAcs;
                        last_q  <= frame_last;
                        aen     <= 1'b1;
                        busy    <= 1'b1;
                    end else begin
                        sym_ready <= 1'b1;
                    end
                end
                StAcs: begin
                    state_q <= StStore;
                    sm_we   <= 1'b1;
                end
                StStore: begin
                    sm_waddr  <= sm_waddr + 1'b1;
                    tb_addr   <= sm_waddr;
                    tb_pend_q <= store_tb;
                    if (min_pm >= PM_W'(NORM_THRESH)) begin
                        state_q     <= StNorm;
                        pm_norm_en  <= 1'b1;
                        pm_norm_val <= min_pm;
`ifdef ACS_NORM_STATS_EN
                        if (norm_count != 8'hFF) begin
                            norm_count <= norm_count + 8'd1;
                        end
`endif
                    end else if (store_tb) begin
                        state_q  <= StTb;
                        tb_start <= 1'b1;
                    end else begin
                        state_q   <= StIdle;
                        sym_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                StNorm: begin
                    if (tb_pend_q) begin
                        state_q  <= StTb;
                        tb_start <= 1'b1;
                    end else begin
                        state_q   <= StIdle;
                        sym_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                StTb: begin
                    if (tb_done) begin
                        state_q   <= StIdle;
                        sym_ready <= 1'b1;
                        busy      <= 1'b0;
                        // Frame end restarts the survivor window from address 0.
                        if (last_q) begin
                            last_q   <= 1'b0;
                            sm_waddr <= '0;
`ifdef ACS_NORM_STATS_EN
                            norm_count <= 8'd0;
`endif
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
